// File: rtl/timer_ctrl.sv
// Countdown sequencing controller: debounces KEY inputs, walks the set/run/pause/done
// sequence, clamps switch BCD, and issues load / 1 Hz decrement / flash drives.

module timer_ctrl_debounce #(
  parameter int unsigned DEBOUNCE = 500_000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_btn_n,
  output logic o_press
);
  localparam int unsigned W = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
  localparam logic [W-1:0] CNT_MAX = W'(DEBOUNCE - 1);

  logic         r_s1, r_s2, r_armed, r_press;
  logic [W-1:0] r_cnt;

  // Armed: count stable-low cycles to fire; disarmed: count stable-high cycles to re-arm.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_s1    <= 1'b1;
      r_s2    <= 1'b1;
      r_armed <= 1'b1;
      r_cnt   <= '0;
      r_press <= 1'b0;
    end else begin
      r_s1    <= i_btn_n;
      r_s2    <= r_s1;
      r_press <= 1'b0;
      if (r_armed == r_s2) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_cnt   <= '0;
        r_armed <= ~r_armed;
        r_press <= r_armed;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_press = r_press;
endmodule

module timer_ctrl #(
  parameter int unsigned TICK_DIV  = 50_000_000,
  parameter int unsigned FLASH_DIV = 25_000_000,
  parameter int unsigned DEBOUNCE  = 500_000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       set_n,
  input  logic       toggle_n,
  input  logic [7:0] sw,
  input  logic       cnt_zero,
  output logic       load_sec,
  output logic       load_min,
  output logic [7:0] load_val,
  output logic       dec_en,
  output logic       flash,
  output logic [2:0] state
);
  localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned FW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
  localparam logic [TW-1:0] TICK_MAX  = TW'(TICK_DIV - 1);
  localparam logic [FW-1:0] FLASH_MAX = FW'(FLASH_DIV - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SET_SEC = 3'd1,
    SET_MIN = 3'd2,
    RUN     = 3'd3,
    PAUSE   = 3'd4,
    DONE    = 3'd5
  } state_t;

  state_t        r_state, w_next;
  logic          w_set, w_tog;
  logic [TW-1:0] r_tick, w_tick;
  logic [FW-1:0] r_fcnt, w_fcnt;
  logic          w_flash, w_dec, w_tick_wrap;
  logic [3:0]    w_tens, w_units, w_tens_max;
  logic [7:0]    w_load_val;

  timer_ctrl_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_set (
    .i_clk(CLOCK_50), .i_reset(reset), .i_btn_n(set_n), .o_press(w_set)
  );

  timer_ctrl_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_tog (
    .i_clk(CLOCK_50), .i_reset(reset), .i_btn_n(toggle_n), .o_press(w_tog)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_set) w_next = SET_SEC;
      SET_SEC: if (w_set) w_next = SET_MIN;
      SET_MIN: if (w_set) w_next = RUN;
      RUN: begin
        if (cnt_zero)   w_next = DONE;
        else if (w_tog) w_next = PAUSE;
      end
      PAUSE: begin
        if (w_set)      w_next = SET_SEC;
        else if (w_tog) w_next = RUN;
      end
      DONE:    if (w_set) w_next = SET_SEC;
      default: w_next = IDLE;
    endcase
  end

  // Outputs decode the next state so loads/flash change on the same edge as the state.
  always_comb begin
    w_tens     = sw[7:4];
    w_units    = sw[3:0];
    w_tens_max = (w_next == SET_SEC) ? 4'd5 : 4'd9;
    w_load_val = {(w_tens > w_tens_max) ? 4'd0 : w_tens,
                  (w_units > 4'd9)      ? 4'd0 : w_units};

    w_tick_wrap = (r_tick == TICK_MAX);
    w_dec       = (r_state == RUN) && w_tick_wrap && !cnt_zero;
    w_tick      = '0;
    if (w_next == RUN || w_next == PAUSE) begin
      if (r_state == RUN) w_tick = w_tick_wrap ? '0 : r_tick + 1'b1;
      else                w_tick = r_tick;
    end

    w_fcnt  = '0;
    w_flash = 1'b0;
    if (w_next == DONE) begin
      if (r_state != DONE) begin
        w_flash = 1'b1;
      end else if (r_fcnt == FLASH_MAX) begin
        w_flash = ~flash;
      end else begin
        w_fcnt  = r_fcnt + 1'b1;
        w_flash = flash;
      end
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      load_sec <= 1'b0;
      load_min <= 1'b0;
      load_val <= '0;
      dec_en   <= 1'b0;
      flash    <= 1'b0;
      r_tick   <= '0;
      r_fcnt   <= '0;
    end else begin
      load_sec <= (w_next == SET_SEC);
      load_min <= (w_next == SET_MIN);
      load_val <= w_load_val;
      dec_en   <= w_dec;
      flash    <= w_flash;
      r_tick   <= w_tick;
      r_fcnt   <= w_fcnt;
    end
  end

  assign state = r_state;
endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl with TICK_DIV=10, FLASH_DIV=5, DEBOUNCE=4.
// Raw button low driven after edge N gives a press pulse after edge N+6 and a new state at N+7.

module tb_timer_ctrl;
  logic       clk = 1'b0;
  logic       reset, set_n, toggle_n, cnt_zero;
  logic [7:0] sw;
  logic       load_sec, load_min, dec_en, flash;
  logic [7:0] load_val;
  logic [2:0] state;

  int checks = 0;
  int errors = 0;
  int n_dec;

  always #5 clk = ~clk;

  timer_ctrl #(.TICK_DIV(10), .FLASH_DIV(5), .DEBOUNCE(4)) dut (
    .CLOCK_50(clk), .reset(reset), .set_n(set_n), .toggle_n(toggle_n),
    .sw(sw), .cnt_zero(cnt_zero), .load_sec(load_sec), .load_min(load_min),
    .load_val(load_val), .dec_en(dec_en), .flash(flash), .state(state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Full press: new state appears 7 edges in; 8 more edges let the button re-arm.
  task automatic press(input logic s, input logic t);
    set_n    = ~s;
    toggle_n = ~t;
    step(7);
    set_n    = 1'b1;
    toggle_n = 1'b1;
    step(8);
  endtask

  initial begin
    reset = 1'b1; set_n = 1'b1; toggle_n = 1'b1; sw = 8'h00; cnt_zero = 1'b0;
    step(2);
    check("rst_state", 32'(state), 0);
    check("rst_load_sec", 32'(load_sec), 0);
    check("rst_load_min", 32'(load_min), 0);
    check("rst_load_val", 32'(load_val), 0);
    check("rst_dec_en", 32'(dec_en), 0);
    check("rst_flash", 32'(flash), 0);
    reset = 1'b0;

    // Short glitch must be filtered
    set_n = 1'b0;
    step(3);
    set_n = 1'b1;
    for (int k = 0; k < 10; k++) begin
      step(1);
      check("short_state", 32'(state), 0);
    end
    check("short_load_sec", 32'(load_sec), 0);

    // Long hold: one press, SET_SEC at edge 7
    set_n = 1'b0;
    step(6);
    check("long_pre_state", 32'(state), 0);
    step(1);
    check("long_state", 32'(state), 1);
    check("long_load_sec", 32'(load_sec), 1);
    step(13);
    check("hold_one_pulse", 32'(state), 1);
    set_n = 1'b1;
    step(8);

    // Clamping in SET_SEC
    sw = 8'h7A; step(1);
    check("clamp_7A", 32'(load_val), 32'h00);
    check("clamp_load_sec", 32'(load_sec), 1);
    sw = 8'h59; step(1);
    check("clamp_59", 32'(load_val), 32'h59);
    sw = 8'h69; step(1);
    check("clamp_69", 32'(load_val), 32'h09);

    press(1'b1, 1'b0);
    check("set_min_state", 32'(state), 2);
    sw = 8'h95; step(1);
    check("clamp_95", 32'(load_val), 32'h95);
    check("clamp_load_min", 32'(load_min), 1);
    check("clamp_no_load_sec", 32'(load_sec), 0);
    sw = 8'hA3; step(1);
    check("clamp_A3", 32'(load_val), 32'h03);

    // Enter RUN: dec_en at 10, 20, 30; toggle raw low after cycle 27 -> PAUSE at 34
    set_n = 1'b0;
    step(7);
    check("run_state", 32'(state), 3);
    check("run_no_load", 32'(load_min), 0);
    set_n = 1'b1;
    for (int k = 1; k <= 30; k++) begin
      step(1);
      check("run_dec", 32'(dec_en), 32'(k % 10 == 0));
      if (k == 27) toggle_n = 1'b0;
    end
    step(3);
    check("pre_pause_state", 32'(state), 3);
    step(1);
    check("pause_state", 32'(state), 4);
    toggle_n = 1'b1;

    n_dec = 0;
    for (int k = 0; k < 50; k++) begin
      step(1);
      if (dec_en) n_dec++;
    end
    check("pause_no_dec", n_dec, 0);
    check("pause_hold", 32'(state), 4);

    // Resume: 4 of 10 counts already used, so dec_en 6 cycles after re-entry
    toggle_n = 1'b0;
    step(7);
    check("resume_state", 32'(state), 3);
    toggle_n = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step(1);
      check("resume_dec", 32'(dec_en), 32'(k == 6));
    end

    // cnt_zero together with toggle pulse on a tick-wrap edge
    step(3);
    toggle_n = 1'b0;
    step(6);
    cnt_zero = 1'b1;
    step(1);
    check("done_state", 32'(state), 5);
    check("done_flash", 32'(flash), 1);
    check("done_dec_gated", 32'(dec_en), 0);
    toggle_n = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      step(1);
      check("flash_wave", 32'(flash), 32'(k < 5 || k >= 10));
    end
    check("done_toggle_ignored", 32'(state), 5);

    set_n = 1'b0;
    step(7);
    check("done_set_state", 32'(state), 1);
    check("done_set_flash", 32'(flash), 0);
    set_n = 1'b1;
    cnt_zero = 1'b0;
    step(8);

    // Set and toggle together in PAUSE
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check("run2_state", 32'(state), 3);
    press(1'b0, 1'b1);
    check("pause2_state", 32'(state), 4);
    press(1'b1, 1'b1);
    check("simul_state", 32'(state), 1);

    // Reset one cycle before a tick would fire
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    check("run3_state", 32'(state), 3);
    step(1);
    reset = 1'b1;
    step(1);
    check("midrun_rst_state", 32'(state), 0);
    check("midrun_rst_dec", 32'(dec_en), 0);
    check("midrun_rst_val", 32'(load_val), 0);
    reset = 1'b0;

    // Entering RUN with 00:00 loaded
    press(1'b1, 1'b0);
    press(1'b1, 1'b0);
    cnt_zero = 1'b1;
    set_n = 1'b0;
    step(7);
    check("zero_run_state", 32'(state), 3);
    set_n = 1'b1;
    step(1);
    check("zero_done_state", 32'(state), 5);
    check("zero_no_dec", 32'(dec_en), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/timer_ctrl.md
# timer_ctrl

Sequencing controller for the four-digit BCD countdown datapath (sec_unit/sec_10/min_unit/min_10 registers plus 7-segment decoders). It conditions the raw KEY buttons, walks the set-seconds → set-minutes → run/pause → done sequence, clamps switch values to legal BCD, and issues load and 1 Hz decrement strobes to the datapath. It replaces the T-flip-flop and pulse-generator glue and drives the LEDR flash.

## Interface
- TICK_DIV, 50_000_000, CLOCK_50 cycles per countdown tick (1 Hz at 50 MHz).
- FLASH_DIV, 25_000_000, cycles per flash half-period.
- DEBOUNCE, 500_000, consecutive stable cycles needed to accept a press or a release.
- CLOCK_50  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high; overrides every other input.
- set_n  in  1  raw KEY[1], active-low, asynchronous to CLOCK_50.
- toggle_n  in  1  raw KEY[2], active-low, asynchronous.
- sw  in  8  SW[7:0]: {tens, units} BCD setting.
- cnt_zero  in  1  datapath flag: all four digits are 0.
- load_sec  out  1  datapath loads sec_10/sec_unit from load_val this cycle.
- load_min  out  1  datapath loads min_10/min_unit from load_val this cycle.
- load_val  out  8  clamped BCD {tens, units}.
- dec_en  out  1  one-cycle decrement strobe.
- flash  out  1  LEDR drive; square wave in DONE, 0 otherwise.
- state  out  3  current state code, for HEX debug.

## Operation
- Button conditioning, per button: 2-flop synchronizer (reset value 1), then a stability counter. A press pulse (1 cycle) fires when the synchronized level has been 0 for DEBOUNCE consecutive cycles. The button then re-arms only after the level has been 1 for DEBOUNCE consecutive cycles. A held button yields exactly one pulse.
- States: IDLE=0, SET_SEC=1, SET_MIN=2, RUN=3, PAUSE=4, DONE=5. Codes 6-7 go to IDLE next cycle.
- State transitions:
  - IDLE, set press → SET_SEC.
  - SET_SEC, set press → SET_MIN.
  - SET_MIN, set press → RUN; the tick prescaler clears to 0.
  - RUN:
    - cnt_zero=1 → DONE. This has priority over a toggle press.
    - Otherwise toggle press → PAUSE.
    - Set press is ignored.
  - PAUSE:
    - Set press → SET_SEC; set wins if set and toggle are pressed in the same cycle.
    - Otherwise toggle press → RUN. The prescaler is not cleared, so the partial second is kept.
  - DONE, set press → SET_SEC.
  - Toggle press is ignored in IDLE, SET_SEC, SET_MIN and DONE.
- Clamping, applied every cycle to sw:
  - In SET_SEC: tens >5 → 0; units >9 → 0.
  - In SET_MIN and all other states: tens >9 → 0; units >9 → 0.
- Loads:
  - load_sec=1 on every cycle the registered state is SET_SEC.
  - load_min=1 on every cycle the registered state is SET_MIN.
  - So the display tracks the switches live. Both are 0 in all other states.
- Tick prescaler:
  - Counts 0..TICK_DIV-1 only while in RUN and wraps to 0.
  - dec_en=1 for the single cycle the count equals TICK_DIV-1, and only if cnt_zero=0.
  - The prescaler holds its value in PAUSE and is 0 in all other states.
- Flash:
  - In DONE, a counter over 0..FLASH_DIV-1 toggles flash on each wrap.
  - On DONE entry the counter clears and flash is set to 1.
  - Leaving DONE forces flash=0 and clears the counter.

## Timing
- All outputs are registered.
- Reset values: state=IDLE, load_sec=0, load_min=0, load_val=0, dec_en=0, flash=0. All counters are 0 and press pulses are 0.
- reset asserted mid-count or in any state returns to the reset values on the next edge. The datapath is cleared by the same reset.
- Raw falling edge to press pulse: DEBOUNCE+2 cycles. Press pulse to new state: 1 cycle. New state to load/flash outputs: same edge, since the outputs decode next-state.
- Transition into RUN: the first dec_en occurs TICK_DIV cycles after entry.
- cnt_zero rising in RUN: DONE is entered on the next edge. No dec_en is issued while cnt_zero=1, so the datapath never wraps below 00:00.
- Entering RUN with 00:00 loaded: DONE after 1 cycle, with zero dec_en pulses.

## Test plan
All scenarios use TICK_DIV=10, FLASH_DIV=5, DEBOUNCE=4.
- Reset/press filtering:
  - Stimulus: reset 2 cycles, then set_n low for 3 cycles, then high.
  - Required: no press pulse; state stays 0; all outputs 0.
  - Stimulus: set_n low for 20 cycles.
  - Required: exactly one pulse; state=1 at cycle DEBOUNCE+3.
- Clamping:
  - Stimulus: in SET_SEC, sw=8'h7A.
  - Required: load_val=8'h00 and load_sec=1.
  - Stimulus: sw=8'h59 → load_val=8'h59.
  - Stimulus: in SET_MIN, sw=8'h95.
  - Required: load_val=8'h95 and load_min=1.
- Run/tick:
  - Stimulus: set press in SET_MIN, cnt_zero=0.
  - Required: state=3; dec_en high exactly on cycles 10, 20, 30 after entry, each 1 cycle wide.
- Pause preserve:
  - Stimulus: toggle press 4 cycles after a dec_en, hold PAUSE 50 cycles, toggle again.
  - Required: no dec_en in PAUSE; next dec_en exactly 6 cycles after RUN re-entry.
- Done/flash:
  - Stimulus: cnt_zero=1 in RUN, simultaneously with a toggle press.
  - Required: state=5 next cycle; flash 1 for 5 cycles, then 0 for 5, repeating.
  - Stimulus: set press in DONE.
  - Required: state=1 and flash=0.
- Simultaneous events:
  - Stimulus: set and toggle pressed together in PAUSE.
  - Required: state=1.
  - Stimulus: reset asserted in RUN mid-prescale.
  - Required: state=0, dec_en=0 next cycle.
